// File: rtl/operand_fetch.sv
// Operand fetch stage: register file, pending-write scoreboard and
// registered operand/control hand-off to the 8-bit ALU.
module operand_fetch #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5,
    parameter int A0_INDEX   = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] rs1,
    input  logic [ADDR_WIDTH-1:0] rs2,
    input  logic [ADDR_WIDTH-1:0] rd,
    input  logic [DATA_WIDTH-1:0] imm,
    input  logic                  aluSrc,
    input  logic [2:0]            aluCtrlIn,
    input  logic                  regWrite,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] aluOp1,
    output logic [DATA_WIDTH-1:0] aluOp2,
    output logic [2:0]            aluCtrl,
    output logic [ADDR_WIDTH-1:0] rd_q,
    output logic                  regWrite_q,
    input  logic                  wb_en,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic [DATA_WIDTH-1:0] a0
);

    localparam int NREG = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] A0_ADDR = ADDR_WIDTH'(A0_INDEX);

    logic [DATA_WIDTH-1:0] regs [NREG];
    logic [NREG-1:0]       busy;

    logic                  wb_live;
    logic                  haz1;
    logic                  haz2;
    logic                  stall;
    logic                  accept;
    logic [DATA_WIDTH-1:0] op1_rd;
    logic [DATA_WIDTH-1:0] op2_rd;

    // Write-first read port: register 0 is hard zero, live writeback bypasses.
    function automatic logic [DATA_WIDTH-1:0] rf_read(
        input logic [ADDR_WIDTH-1:0] a
    );
        if (a == '0)
            return '0;
        else if (wb_live && wb_addr == a)
            return wb_data;
        else
            return regs[a];
    endfunction

    // A source waits only on a pending write not being retired this cycle.
    function automatic logic hazard(input logic [ADDR_WIDTH-1:0] a);
        return (a != '0) && busy[a] && !(wb_live && wb_addr == a);
    endfunction

    assign wb_live  = wb_en && (wb_addr != '0);
    assign haz1     = hazard(rs1);
    assign haz2     = !aluSrc && hazard(rs2);
    assign stall    = in_valid && (haz1 || haz2);
    assign in_ready = !stall && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign op1_rd   = rf_read(rs1);
    assign op2_rd   = aluSrc ? imm : rf_read(rs2);
    assign a0       = rf_read(A0_ADDR);

    // Architectural register file, written only by the writeback port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= '0;
        end else if (wb_live) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // Pending-write bits: a new claim on rd overrides a same-edge retire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            if (wb_live)
                busy[wb_addr] <= 1'b0;
            if (accept && regWrite && rd != '0)
                busy[rd] <= 1'b1;
        end
    end

    // Output register: load on accept, drop valid once consumed, else hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            aluOp1     <= '0;
            aluOp2     <= '0;
            aluCtrl    <= '0;
            rd_q       <= '0;
            regWrite_q <= 1'b0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            aluOp1     <= op1_rd;
            aluOp2     <= op2_rd;
            aluCtrl    <= aluCtrlIn;
            rd_q       <= rd;
            regWrite_q <= regWrite;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Scoreboard bench for operand_fetch: directed issue sequence with
// hand-computed operands, outputs checked by an independent monitor.
module tb_operand_fetch;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] rs1, rs2, rd;
    logic [7:0] imm;
    logic       aluSrc;
    logic [2:0] aluCtrlIn;
    logic       regWrite;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] aluOp1, aluOp2;
    logic [2:0] aluCtrl;
    logic [4:0] rd_q;
    logic       regWrite_q;
    logic       wb_en;
    logic [4:0] wb_addr;
    logic [7:0] wb_data;
    logic [7:0] a0;

    typedef struct packed {
        logic [7:0] op1;
        logic [7:0] op2;
        logic [2:0] ctrl;
        logic [4:0] rdd;
        logic       rw;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    operand_fetch dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm),
        .aluSrc(aluSrc), .aluCtrlIn(aluCtrlIn), .regWrite(regWrite),
        .out_valid(out_valid), .out_ready(out_ready),
        .aluOp1(aluOp1), .aluOp2(aluOp2), .aluCtrl(aluCtrl),
        .rd_q(rd_q), .regWrite_q(regWrite_q),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .a0(a0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus; an accepted instruction queues its expectation.
    task automatic step(
        input logic       v,
        input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d,
        input logic [7:0] im, input logic src, input logic [2:0] ctl,
        input logic       rw,
        input logic       we, input logic [4:0] wa, input logic [7:0] wd,
        input logic       ordy, input logic exp_rdy,
        input logic [7:0] e1, input logic [7:0] e2
    );
        @(negedge clk);
        in_valid  = v;
        rs1       = r1;
        rs2       = r2;
        rd        = d;
        imm       = im;
        aluSrc    = src;
        aluCtrlIn = ctl;
        regWrite  = rw;
        wb_en     = we;
        wb_addr   = wa;
        wb_data   = wd;
        out_ready = ordy;
        #1;
        if (v) begin
            chk("in_ready", 32'(in_ready), 32'(exp_rdy));
            if (exp_rdy)
                q.push_back('{op1: e1, op2: e2, ctrl: ctl, rdd: d, rw: rw});
        end
    endtask

    task automatic idle(input logic we, input logic [4:0] wa,
                        input logic [7:0] wd, input logic ordy);
        step(0, 0, 0, 0, 0, 0, 0, 0, we, wa, wd, ordy, 0, 0, 0);
    endtask

    // Monitor: every transfer (valid and ready) must match the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (rst_n && out_valid && out_ready) begin
                if (q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_out: got op1=0x%0h op2=0x%0h expected none",
                             aluOp1, aluOp2);
                end else begin
                    e = q.pop_front();
                    chk("aluOp1", 32'(aluOp1), 32'(e.op1));
                    chk("aluOp2", 32'(aluOp2), 32'(e.op2));
                    chk("aluCtrl", 32'(aluCtrl), 32'(e.ctrl));
                    chk("rd_q", 32'(rd_q), 32'(e.rdd));
                    chk("regWrite_q", 32'(regWrite_q), 32'(e.rw));
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        in_valid = 0; rs1 = 0; rs2 = 0; rd = 0; imm = 0; aluSrc = 0;
        aluCtrlIn = 0; regWrite = 0; wb_en = 0; wb_addr = 0; wb_data = 0;
        out_ready = 1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_aluOp1", 32'(aluOp1), 0);
        chk("rst_aluOp2", 32'(aluOp2), 0);
        chk("rst_aluCtrl", 32'(aluCtrl), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_a0", 32'(a0), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // writeback then immediate-form read
        idle(1, 3, 8'h2A, 1);
        step(1, 3, 0, 0, 8'h05, 1, 0, 0, 0, 0, 0, 1, 1, 8'h2A, 8'h05);
        // claim r4, then stall until its writeback arrives (bypassed)
        step(1, 3, 0, 4, 8'h00, 0, 1, 1, 0, 0, 0, 1, 1, 8'h2A, 8'h00);
        step(1, 4, 0, 5, 8'h22, 1, 2, 0, 0, 0, 0, 1, 0, 0, 0);
        step(1, 4, 0, 5, 8'h22, 1, 2, 0, 1, 4, 8'h11, 1, 1, 8'h11, 8'h22);
        // register 0 ignores writes and reads zero
        idle(1, 0, 8'hFF, 1);
        step(1, 0, 0, 0, 8'h00, 0, 3, 1, 0, 0, 0, 1, 1, 8'h00, 8'h00);
        step(1, 3, 0, 0, 8'h00, 0, 4, 0, 0, 0, 0, 1, 1, 8'h2A, 8'h00);
        // rs2 only hazards when used
        step(1, 3, 0, 6, 8'h01, 1, 0, 1, 0, 0, 0, 1, 1, 8'h2A, 8'h01);
        step(1, 3, 6, 0, 8'h09, 1, 1, 0, 0, 0, 0, 1, 1, 8'h2A, 8'h09);
        step(1, 3, 6, 0, 8'h00, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0);
        idle(1, 6, 8'h33, 1);
        step(1, 6, 6, 0, 8'h00, 0, 7, 0, 0, 0, 0, 1, 1, 8'h33, 8'h33);
        idle(0, 0, 0, 1);
        // backpressure: hold three cycles, then back-to-back
        step(1, 3, 0, 7, 8'h44, 1, 5, 0, 0, 0, 0, 0, 1, 8'h2A, 8'h44);
        for (int i = 0; i < 3; i++) begin
            step(1, 3, 0, 8, 8'h55, 1, 6, 1, 0, 0, 0, 0, 0, 0, 0);
            chk("hold_valid", 32'(out_valid), 1);
            chk("hold_op1", 32'(aluOp1), 32'h2A);
            chk("hold_op2", 32'(aluOp2), 32'h44);
            chk("hold_ctrl", 32'(aluCtrl), 5);
            chk("hold_rd", 32'(rd_q), 7);
        end
        step(1, 3, 0, 8, 8'h55, 1, 6, 1, 0, 0, 0, 1, 1, 8'h2A, 8'h55);
        step(1, 0, 0, 9, 8'h66, 1, 2, 0, 0, 0, 0, 1, 1, 8'h00, 8'h66);
        chk("b2b_valid", 32'(out_valid), 1);
        idle(0, 0, 0, 1);
        chk("b2b_valid2", 32'(out_valid), 1);
        // a0 sees the writeback in the same cycle and keeps it
        idle(1, 10, 8'h7F, 1);
        chk("a0_bypass", 32'(a0), 32'h7F);
        idle(0, 0, 0, 1);
        chk("a0_held", 32'(a0), 32'h7F);
        // reset mid-stall with a held output and r4 pending
        step(1, 0, 0, 4, 8'h01, 1, 0, 1, 0, 0, 0, 1, 1, 8'h00, 8'h01);
        step(1, 4, 0, 0, 8'h00, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("pre_rst_valid", 32'(out_valid), 1);
        in_valid = 0;
        rst_n = 1'b0;
        q.delete();
        #1;
        chk("midrst_valid", 32'(out_valid), 0);
        chk("midrst_op2", 32'(aluOp2), 0);
        chk("midrst_a0", 32'(a0), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 4, 0, 0, 8'h00, 0, 1, 0, 0, 0, 0, 1, 1, 8'h00, 8'h00);
        idle(0, 0, 0, 1);
        repeat (3) idle(0, 0, 0, 1);
        chk("queue_drained", 32'(q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
